// File: rtl/baud_tick_gen.sv
// Clock-enable baud generator: os_tick at OVERSAMPLE x baud and baud_tick at baud.
// It has four presets, a custom divisor and an RX resync. Define BAUD_FRAC_EN to add the fractional accumulator.
module baud_tick_gen #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int OVERSAMPLE = 8,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4,
  localparam int PH_W      = $clog2(OVERSAMPLE)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [1:0]        sel_baud,
  input  logic              use_custom,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [FRAC_W-1:0] cfg_frac,
  input  logic              cfg_load,
  input  logic              resync,
  output logic              os_tick,
  output logic              baud_tick,
  output logic [PH_W-1:0]   os_phase,
  output logic              cfg_err
);

  function automatic longint baud_rate(input int sel);
    case (sel)
      0:       return 64'd9600;
      1:       return 64'd19200;
      2:       return 64'd57600;
      default: return 64'd115200;
    endcase
  endfunction

  function automatic logic [DIV_W-1:0] preset_div(input int sel);
    return DIV_W'(longint'(CLK_HZ) / (baud_rate(sel) * longint'(OVERSAMPLE)));
  endfunction

  localparam logic [DIV_W-1:0] PRE_DIV [4] = '{preset_div(0), preset_div(1),
                                               preset_div(2), preset_div(3)};

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] d_act_q, d_act_d;
  logic [DIV_W-1:0] sh_div_q, sh_div_d;
  logic             pend_q, pend_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             os_tick_q, os_tick_d;
  logic             baud_q, baud_d;
  logic             err_q, err_d;
  logic             stretch;
  logic [DIV_W-1:0] src_div;
  logic [DIV_W-1:0] last;
  logic             load_ok;

`ifdef BAUD_FRAC_EN
  function automatic logic [FRAC_W-1:0] preset_frac(input int sel);
    longint den;
    longint rem;
    den = baud_rate(sel) * longint'(OVERSAMPLE);
    rem = longint'(CLK_HZ) % den;
    return FRAC_W'((rem * (longint'(1) << FRAC_W) + den / 2) / den);
  endfunction

  localparam logic [FRAC_W-1:0] PRE_FRAC [4] = '{preset_frac(0), preset_frac(1),
                                                 preset_frac(2), preset_frac(3)};

  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              stretch_q, stretch_d;
  logic [FRAC_W-1:0] f_act_q, f_act_d;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
  logic [FRAC_W-1:0] src_frac;
  logic [FRAC_W:0]   acc_sum;

  assign stretch  = stretch_q;
  assign src_frac = use_custom ? cfg_frac : PRE_FRAC[sel_baud];
  assign acc_sum  = {1'b0, acc_q} + {1'b0, f_act_q};
`else
  logic unused_frac;
  assign unused_frac = ^cfg_frac;
  assign stretch     = 1'b0;
`endif

  assign src_div = use_custom ? cfg_div : PRE_DIV[sel_baud];
  assign load_ok = cfg_load && (src_div >= DIV_W'(2));
  assign last    = d_act_q - DIV_W'(1) + DIV_W'(stretch);

  always_comb begin
    cnt_d     = cnt_q;
    d_act_d   = d_act_q;
    sh_div_d  = sh_div_q;
    pend_d    = pend_q;
    phase_d   = phase_q;
    os_tick_d = 1'b0;
    baud_d    = 1'b0;
    err_d     = err_q;
`ifdef BAUD_FRAC_EN
    acc_d     = acc_q;
    stretch_d = stretch_q;
    f_act_d   = f_act_q;
    sh_frac_d = sh_frac_q;
`endif
    if (resync) begin
      cnt_d   = '0;
      phase_d = PH_W'(OVERSAMPLE / 2);
`ifdef BAUD_FRAC_EN
      acc_d     = '0;
      stretch_d = 1'b0;
`endif
    end else if (enable) begin
      // >= so a shorter divisor applied mid-period still wraps promptly.
      if (cnt_q >= last) begin
        cnt_d     = '0;
        os_tick_d = 1'b1;
        phase_d   = phase_q + PH_W'(1);
        baud_d    = (phase_q == PH_W'(OVERSAMPLE - 1));
`ifdef BAUD_FRAC_EN
        acc_d     = acc_sum[FRAC_W-1:0];
        stretch_d = acc_sum[FRAC_W];
`endif
        if (pend_q) begin
          d_act_d = sh_div_q;
          pend_d  = 1'b0;
`ifdef BAUD_FRAC_EN
          f_act_d = sh_frac_q;
`endif
        end
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end else if (pend_q) begin
      d_act_d = sh_div_q;
      pend_d  = 1'b0;
`ifdef BAUD_FRAC_EN
      f_act_d = sh_frac_q;
`endif
    end
    // A load in the same cycle as an apply re-arms pending with the newer value.
    if (cfg_load) begin
      if (load_ok) begin
        sh_div_d = src_div;
        pend_d   = 1'b1;
        err_d    = 1'b0;
`ifdef BAUD_FRAC_EN
        sh_frac_d = src_frac;
`endif
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      d_act_q   <= PRE_DIV[0];
      sh_div_q  <= PRE_DIV[0];
      pend_q    <= 1'b0;
      phase_q   <= '0;
      os_tick_q <= 1'b0;
      baud_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef BAUD_FRAC_EN
      acc_q     <= '0;
      stretch_q <= 1'b0;
      f_act_q   <= PRE_FRAC[0];
      sh_frac_q <= PRE_FRAC[0];
`endif
    end else begin
      cnt_q     <= cnt_d;
      d_act_q   <= d_act_d;
      sh_div_q  <= sh_div_d;
      pend_q    <= pend_d;
      phase_q   <= phase_d;
      os_tick_q <= os_tick_d;
      baud_q    <= baud_d;
      err_q     <= err_d;
`ifdef BAUD_FRAC_EN
      acc_q     <= acc_d;
      stretch_q <= stretch_d;
      f_act_q   <= f_act_d;
      sh_frac_q <= sh_frac_d;
`endif
    end
  end

  assign os_tick   = os_tick_q;
  assign baud_tick = baud_q;
  assign os_phase  = phase_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: directed sequences, a table of config loads and random stimulus.
// A cycle-level integer reference model checks every output on every clock.
module tb_baud_tick_gen;
  localparam int OS  = 8;
  localparam int DW  = 16;
  localparam int FW  = 4;
  localparam int PHW = 3;
`ifdef BAUD_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    sel_baud = 2'd0;
  logic          use_custom = 1'b0;
  logic [DW-1:0] cfg_div = '0;
  logic [FW-1:0] cfg_frac = '0;
  logic          cfg_load = 1'b0;
  logic          resync = 1'b0;
  logic          os_tick, baud_tick, cfg_err;
  logic [PHW-1:0] os_phase;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  baud_tick_gen dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sel_baud(sel_baud),
    .use_custom(use_custom), .cfg_div(cfg_div), .cfg_frac(cfg_frac),
    .cfg_load(cfg_load), .resync(resync), .os_tick(os_tick),
    .baud_tick(baud_tick), .os_phase(os_phase), .cfg_err(cfg_err)
  );

  // Reference model: elapsed cycles in period, integer fractional sum.
  int pre_d [4] = '{1302, 651, 217, 108};
  int pre_f [4] = '{1, 1, 0, 8};
  int m_d, m_f, m_sd, m_sf, m_el, m_acc, m_str, m_ph;
  bit m_pend, m_err, m_tick, m_baud;

  task automatic model_reset();
    m_d = pre_d[0]; m_f = FRAC_ON ? pre_f[0] : 0;
    m_sd = m_d; m_sf = m_f;
    m_el = 0; m_acc = 0; m_str = 0; m_ph = 0;
    m_pend = 0; m_err = 0; m_tick = 0; m_baud = 0;
  endtask

  task automatic model_edge();
    int sd, sf;
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_tick = 0; m_baud = 0;
    if (resync) begin
      m_el = 0; m_acc = 0; m_str = 0; m_ph = OS / 2;
    end else if (enable) begin
      if (m_el + 1 >= m_d + m_str) begin
        m_el = 0; m_tick = 1;
        m_baud = (m_ph == OS - 1);
        m_ph = (m_ph + 1) % OS;
        m_acc = m_acc + m_f;
        m_str = (m_acc >= (1 << FW)) ? 1 : 0;
        m_acc = m_acc % (1 << FW);
        if (m_pend) begin m_d = m_sd; m_f = m_sf; m_pend = 0; end
      end else begin
        m_el++;
      end
    end else if (m_pend) begin
      m_d = m_sd; m_f = m_sf; m_pend = 0;
    end
    if (cfg_load) begin
      sd = use_custom ? int'(cfg_div) : pre_d[sel_baud];
      sf = FRAC_ON ? (use_custom ? int'(cfg_frac) : pre_f[sel_baud]) : 0;
      if (sd < 2) m_err = 1;
      else begin m_sd = sd; m_sf = sf; m_pend = 1; m_err = 0; end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check("os_tick", int'(os_tick), int'(m_tick));
    check("baud_tick", int'(baud_tick), int'(m_baud));
    check("os_phase", int'(os_phase), m_ph);
    check("cfg_err", int'(cfg_err), int'(m_err));
  endtask

  task automatic run_ticks(input int n, input int budget, output int t_first,
                           output int t_last, output int n_baud);
    int seen;
    seen = 0; t_first = -1; t_last = -1; n_baud = 0;
    for (int i = 0; i < budget && seen < n; i++) begin
      step();
      if (os_tick) begin
        seen++;
        if (seen == 1) t_first = cyc;
        t_last = cyc;
      end
      if (baud_tick) n_baud++;
    end
    if (seen < n) check("tick_timeout", seen, n);
  endtask

  task automatic load(input bit uc, input logic [1:0] sel, input int div);
    use_custom = uc; sel_baud = sel; cfg_div = DW'(div); cfg_frac = '0;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  typedef struct {
    bit         uc;
    logic [1:0] sel;
    int         div;
    bit         exp_err;
  } load_vec_t;

  load_vec_t vecs [6];

  initial begin
    int tf, tl, nb, cur_d, rel, rs_cyc;
    vecs[0] = '{uc: 1'b1, sel: 2'd0, div: 4,  exp_err: 1'b0};
    vecs[1] = '{uc: 1'b1, sel: 2'd0, div: 1,  exp_err: 1'b1};
    vecs[2] = '{uc: 1'b1, sel: 2'd0, div: 10, exp_err: 1'b0};
    vecs[3] = '{uc: 1'b1, sel: 2'd0, div: 0,  exp_err: 1'b1};
    vecs[4] = '{uc: 1'b0, sel: 2'd2, div: 0,  exp_err: 1'b0};
    vecs[5] = '{uc: 1'b1, sel: 2'd0, div: 4,  exp_err: 1'b0};

    model_reset();
    for (int i = 0; i < 3; i++) step();
    check("rst_phase", int'(os_phase), 0);
    reset_n = 1'b1;

    // Preset 115200, loaded while disabled so it takes effect on the next clock.
    load(1'b0, 2'd3, 0);
    step();
    enable = 1'b1;
    run_ticks(17, 3000, tf, tl, nb);
    check("preset11_span16", tl - tf, FRAC_ON ? 1736 : 1728);
    check("preset11_baud_cnt", nb, 2);

    cur_d = 108;
    foreach (vecs[i]) begin
      load(vecs[i].uc, vecs[i].sel, vecs[i].div);
      check("tbl_cfg_err", int'(cfg_err), int'(vecs[i].exp_err));
      if (!vecs[i].exp_err) cur_d = vecs[i].uc ? vecs[i].div : pre_d[vecs[i].sel];
      run_ticks(1, 3000, tf, tl, nb);
      run_ticks(2, 3000, tf, tl, nb);
      check("tbl_period", tl - tf, cur_d);
    end

    // Resync exactly on a would-be wrap (D=4, count 3).
    run_ticks(1, 100, tf, tl, nb);
    for (int i = 0; i < 3; i++) step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    rs_cyc = cyc;
    check("resync_suppress", int'(os_tick), 0);
    check("resync_phase", int'(os_phase), OS / 2);
    run_ticks(4, 100, tf, tl, nb);
    check("resync_first_gap", tf - rs_cyc, 4);
    check("resync_baud_cnt", nb, 1);
    check("resync_baud_4th", int'(baud_tick), 1);

    // Reset mid-period with custom D=10.
    load(1'b1, 2'd0, 10);
    run_ticks(2, 100, tf, tl, nb);
    for (int i = 0; i < 3; i++) step();
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_phase", int'(os_phase), 0);
    check("async_rst_tick", int'(os_tick), 0);
    model_reset();
    step(); step();
    reset_n = 1'b1;
    rel = cyc;
    run_ticks(3, 5000, tf, tl, nb);
    check("post_rst_first", tf - rel, 1302);
    check("post_rst_span2", tl - tf, 2604);

    // Enable low for 50 cycles, loading D=30 while frozen.
    load(1'b1, 2'd0, 20);
    run_ticks(2, 3000, tf, tl, nb);
    for (int i = 0; i < 5; i++) step();
    enable = 1'b0;
    nb = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 20) begin
        use_custom = 1'b1; cfg_div = DW'(30); cfg_frac = '0; cfg_load = 1'b1;
      end else begin
        cfg_load = 1'b0;
      end
      step();
      if (os_tick) nb++;
    end
    check("disabled_no_ticks", nb, 0);
    enable = 1'b1;
    rel = cyc;
    run_ticks(1, 200, tf, tl, nb);
    check("resume_residual", tf - rel, 25);
    run_ticks(2, 200, tf, tl, nb);
    check("resume_period", tl - tf, 30);

    // Randomised stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      enable     = ($urandom_range(0, 9) != 0);
      resync     = ($urandom_range(0, 99) == 0);
      cfg_load   = ($urandom_range(0, 39) == 0);
      use_custom = ($urandom_range(0, 7) != 0);
      sel_baud   = 2'($urandom_range(0, 3));
      cfg_div    = DW'($urandom_range(0, 12));
      cfg_frac   = FW'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised successor baud generator for the UART front-end: produces single-cycle clock-enable ticks in the `clk` domain (oversample tick and bit tick) instead of derived clocks. Supports four compile-time presets, a runtime custom divisor with fractional correction, glitch-free reconfiguration at tick boundaries, and an RX resync for start-bit centring. Feeds the UART RX sampler (`os_tick`, `os_phase`) and TX shifter (`baud_tick`).

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency used to compute presets.
- `OVERSAMPLE`, 8, `os_tick`s per bit; power of two, ≥2.
- `DIV_W`, 16, integer divisor width.
- `FRAC_W`, 4, fractional divisor width (units of 1/2^FRAC_W cycle).
- `clk` input 1 system clock.
- `reset_n` input 1 asynchronous, active-low reset.
- `enable` input 1 run; low freezes all counters.
- `sel_baud` input 2 preset: 00=9600, 01=19200, 10=57600, 11=115200.
- `use_custom` input 1 1 selects `cfg_div`/`cfg_frac` instead of preset.
- `cfg_div` input DIV_W custom integer divisor D.
- `cfg_frac` input FRAC_W custom fractional part F.
- `cfg_load` input 1 one-cycle pulse: capture selection into shadow.
- `resync` input 1 one-cycle pulse: restart bit timing at half-bit.
- `os_tick` output 1 one-cycle pulse at OVERSAMPLE×baud.
- `baud_tick` output 1 one-cycle pulse at baud.
- `os_phase` output log2(OVERSAMPLE) oversample index within bit.
- `cfg_err` output 1 sticky: last `cfg_load` rejected.

## Operation
- Preset D = floor(CLK_HZ/(baud·OVERSAMPLE)); F = round-to-nearest(remainder·2^FRAC_W/(baud·OVERSAMPLE)), computed at elaboration. Defaults: 9600→(1302,1), 19200→(651,1), 57600→(217,0), 115200→(108,8).
- Active registers {D_act, F_act}; reset value = preset 00.
- Period counter `cnt` counts 0..P-1, P = D_act + stretch. At wrap: `os_tick` pulses, acc ← acc + F_act (FRAC_W+1 bits, low FRAC_W kept), stretch ← carry. Mean period = D + F/2^FRAC_W.
- `os_phase` increments on each `os_tick`, wraps OVERSAMPLE-1→0; `baud_tick` pulses with the `os_tick` that wraps `os_phase` to 0.
- `cfg_load`: source = custom if `use_custom` else preset[`sel_baud`]. If source D < 2: rejected, `cfg_err` ← 1, shadow unchanged. Else shadow ← source, pending ← 1, `cfg_err` ← 0.
- Pending shadow copies to active on the next `os_tick` (new D used for the following period); if `enable`=0, copies on the next clock. Back-to-back loads: last valid wins.
- `resync`: cnt ← 0, acc ← 0, stretch ← 0, `os_phase` ← OVERSAMPLE/2; suppresses any tick that cycle. Next `baud_tick` falls OVERSAMPLE/2 `os_tick`s later (bit centre). Pending config is not applied on a suppressed tick.
- `enable`=0: cnt, acc, `os_phase` hold; ticks 0.

## Timing
- All outputs registered. Reset (async assert, sync release): `os_tick`=0, `baud_tick`=0, `os_phase`=0, `cfg_err`=0, cnt=0, acc=0, pending=0.
- First `os_tick` on the D-th enabled rising edge after reset release; thereafter every P enabled edges.
- `cfg_err` updates the edge after `cfg_load`.
- Priority, same cycle: reset > resync > tick/config apply.
- Reset mid-period: period discarded, config returns to preset 00.

## Configuration
- `BAUD_FRAC_EN` defined: fractional accumulator present as above.
- Undefined: acc/stretch removed, F forced 0, `cfg_frac` ignored; period exactly D_act.

## Test plan
- Reset, enable=1, sel_baud=11: 16 `os_tick`s span 1736 cycles (8 periods of 109, 8 of 108 alternating); `baud_tick` on every 8th `os_tick`, `os_phase` 0..7.
- use_custom=1, cfg_div=4, cfg_frac=0, `cfg_load`: after current period, `os_tick` every 4 cycles, `baud_tick` every 32.
- `cfg_load` with cfg_div=1 → `cfg_err`=1, period unchanged; then cfg_div=10 → `cfg_err`=0, period 10 from next `os_tick`.
- `resync` mid-period (D=4): ticks suppressed that cycle, next `os_tick` 4 cycles later, `baud_tick` on 4th `os_tick` after resync.
- `reset_n` low mid-period with custom D=10: outputs 0 immediately; after release, `os_tick` period 1302/1303 (preset 00).
- `enable` low for 50 cycles: no ticks, cnt/`os_phase` frozen; resume continues residual period; `cfg_load` during low applies next clock.
